mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage plus MEM/WB register; consumes the EX/MEM register outputs.
//  Runs a req/ack data-memory handshake, stalls upstream while an access is
//  outstanding, and registers the results for writeback.
//  Resolves branches: taken when mem_branch and mem_alu_result==0.
// PARAMETERS
//  PC_WIDTH       12  program-counter width
//  DATA_WIDTH     16  datapath width; also the dmem address width
//  REGADDR_WIDTH  3   register-file address width
//  TIMEOUT_CYCLES 15  cycles in ACCESS without ack before abort (MEM_TIMEOUT_EN only)
// PORTS
//  clk            in   1   clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  mem_reg_write  in   1   from EX/MEM: write register file
//  mem_mem_read   in   1   from EX/MEM: load
//  mem_mem_write  in   1   from EX/MEM: store
//  mem_branch     in   1   from EX/MEM: branch instruction
//  mem_pc         in   PC  from EX/MEM: branch target
//  mem_alu_result in   DW  from EX/MEM: address or ALU result
//  mem_write_data in   DW  from EX/MEM: store data
//  mem_rd         in   RA  from EX/MEM: destination register
//  dmem_req       out  1   memory request, high only in ACCESS
//  dmem_we        out  1   1=write, 0=read; valid with dmem_req
//  dmem_addr      out  DW  mem_alu_result
//  dmem_wdata     out  DW  mem_write_data
//  dmem_rdata     in   DW  read data, sampled when dmem_ack=1
//  dmem_ack       in   1   access complete, single-cycle pulse
//  stall          out  1   freeze PC, IF/ID, ID/EX and EX/MEM
//  branch_taken   out  1   mem_branch & (mem_alu_result==0) & ~stall
//  branch_target  out  PC  mem_pc
//  wb_valid       out  1   MEM/WB holds a real instruction
//  wb_reg_write   out  1   registered reg-write enable
//  wb_mem_to_reg  out  1   1=select wb_read_data, 0=select wb_alu_result
//  wb_alu_result  out  DW  registered ALU result
//  wb_read_data   out  DW  registered load data
//  wb_rd          out  RA  registered destination register
//  mem_err        out  1   sticky timeout flag
// BEHAVIOUR
//  Reset (reset_n=0, takes effect immediately): FSM=IDLE; every registered
//   output=0; dmem_req=0; stall=0.
//  FSM states are IDLE and ACCESS. access = mem_mem_read | mem_mem_write.
//   IDLE: if access, go to ACCESS next cycle; stall=1 this cycle; MEM/WB loads a
//    bubble (all wb_* = 0). Otherwise MEM/WB loads the instruction: wb_valid=1,
//    wb_mem_to_reg=0, wb_read_data=0.
//   ACCESS: dmem_req=1. stall = ~dmem_ack.
//    On ack: capture dmem_rdata into wb_read_data; wb_valid=1;
//     wb_mem_to_reg = read access; wb_reg_write = mem_reg_write; go to IDLE.
//    No ack: MEM/WB loads a bubble.
//  Latency: non-memory op reaches MEM/WB in 1 cycle. Memory op needs
//   2 + (ack wait) cycles; minimum is 2 when ack arrives in the first ACCESS cycle.
//  Upstream holds all mem_* inputs stable while stall=1. The stage samples the
//   inputs every cycle regardless.
//  Read and write both set: handled as a write (dmem_we=1, wb_mem_to_reg=0).
//  branch_taken is combinational and is masked while stall=1.
//  dmem_ack while in IDLE is ignored.
//  A reset during ACCESS drops dmem_req immediately. A late ack after reset is ignored.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - A 4+ bit counter clears on entry to ACCESS and increments each ACCESS
//     cycle without ack.
//   - When the count reaches TIMEOUT_CYCLES: set mem_err (sticky until reset),
//     deassert req/stall, go to IDLE, and write MEM/WB with wb_valid=1,
//     wb_reg_write=0 (squashed).
//   - Ack in the same cycle as the timeout: ack wins.
//  MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely; mem_err is tied to 0.
// TESTING
//  1 ALU op: reg_write=1, alu_result=16'h0042, rd=3 -> next cycle
//    wb_valid=1, wb_alu_result=16'h0042, wb_rd=3, stall=0.
//  2 Load: addr 16'h0010, ack 3 cycles after req, rdata=16'hBEEF -> stall high for
//    4 cycles; then wb_read_data=16'hBEEF, wb_mem_to_reg=1; bubbles meanwhile.
//  3 Store: addr 16'h0020, data 16'h1234, ack in first ACCESS cycle ->
//    dmem_we=1 for one cycle; wb_reg_write=0; total stall 1 cycle.
//  4 Branch: mem_branch=1, alu_result=0, pc=12'h0A4 -> branch_taken=1,
//    target 12'h0A4; same with alu_result=1 -> branch_taken=0.
//  5 Reset: reset_n pulled low mid-ACCESS -> dmem_req/stall drop the same cycle,
//    all wb_*=0; later ack ignored.
//  6 MEM_TIMEOUT_EN: no ack -> after 15 cycles mem_err=1 (sticky), stall=0,
//    wb_reg_write=0; ack on cycle 15 -> normal completion, mem_err=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage with MEM/WB register: req/ack data-memory handshake,
// upstream stall, branch resolution. Optional access timeout: MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int PC_WIDTH       = 12,
  parameter int DATA_WIDTH     = 16,
  parameter int REGADDR_WIDTH  = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_read,
  input  logic                     mem_mem_write,
  input  logic                     mem_branch,
  input  logic [PC_WIDTH-1:0]      mem_pc,
  input  logic [DATA_WIDTH-1:0]    mem_alu_result,
  input  logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [REGADDR_WIDTH-1:0] mem_rd,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [DATA_WIDTH-1:0]    dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  input  logic                     dmem_ack,
  output logic                     stall,
  output logic                     branch_taken,
  output logic [PC_WIDTH-1:0]      branch_target,
  output logic                     wb_valid,
  output logic                     wb_reg_write,
  output logic                     wb_mem_to_reg,
  output logic [DATA_WIDTH-1:0]    wb_alu_result,
  output logic [DATA_WIDTH-1:0]    wb_read_data,
  output logic [REGADDR_WIDTH-1:0] wb_rd,
  output logic                     mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic                     valid;
    logic                     reg_write;
    logic                     mem_to_reg;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    read_data;
    logic [REGADDR_WIDTH-1:0] rd;
  } wb_t;

  state_t state_q, state_d;
  wb_t    wb_q, wb_d;
  logic   access;
  logic   stall_c;
  logic   timeout;

  assign access = mem_mem_read | mem_mem_write;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Fires on the last allowed ACCESS cycle; an ack in that same cycle wins.
  assign timeout = (state_q == ACCESS) && !dmem_ack &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE)
        cnt_q <= '0;
      else if (!dmem_ack)
        cnt_q <= cnt_q + 1'b1;
      if (timeout)
        err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    wb_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = ACCESS;
          stall_c = 1'b1;
        end else begin
          wb_d.valid      = 1'b1;
          wb_d.reg_write  = mem_reg_write;
          wb_d.alu_result = mem_alu_result;
          wb_d.rd         = mem_rd;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d         = IDLE;
          wb_d.valid      = 1'b1;
          wb_d.reg_write  = mem_reg_write;
          wb_d.mem_to_reg = mem_mem_read & ~mem_mem_write;
          wb_d.alu_result = mem_alu_result;
          wb_d.read_data  = dmem_rdata;
          wb_d.rd         = mem_rd;
        end else if (timeout) begin
          state_d         = IDLE;
          wb_d.valid      = 1'b1;
          wb_d.alu_result = mem_alu_result;
          wb_d.rd         = mem_rd;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  // Reset gates stall so upstream is released the moment reset asserts.
  assign stall         = reset_n & stall_c;
  assign dmem_req      = (state_q == ACCESS);
  assign dmem_we       = dmem_req & mem_mem_write;
  assign dmem_addr     = mem_alu_result;
  assign dmem_wdata    = mem_write_data;
  assign branch_taken  = mem_branch & (mem_alu_result == '0) & ~stall;
  assign branch_target = mem_pc;

  assign wb_valid      = wb_q.valid;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_read_data  = wb_q.read_data;
  assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instructions checked against a transaction-level model. Honours MEM_TIMEOUT_EN.
module tb_mem_access_stage;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_branch;
  logic [11:0] mem_pc;
  logic [15:0] mem_alu_result, mem_write_data;
  logic [2:0]  mem_rd;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, branch_taken;
  logic [11:0] branch_target;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [15:0] wb_alu_result, wb_read_data;
  logic [2:0]  wb_rd;
  logic        mem_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_err  = 1'b0;

  mem_access_stage #(
    .PC_WIDTH(12), .DATA_WIDTH(16), .REGADDR_WIDTH(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
    .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_rd(mem_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data), .wb_rd(wb_rd),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic expect_wb(input string tag, input logic v, input logic rw, input logic m2r,
                           input logic [15:0] alu, input logic [15:0] rdat, input logic [2:0] rd);
    check({tag, "_valid"},      wb_valid,      v);
    check({tag, "_reg_write"},  wb_reg_write,  rw);
    check({tag, "_mem_to_reg"}, wb_mem_to_reg, m2r);
    check({tag, "_alu"},        wb_alu_result, alu);
    check({tag, "_rdata"},      wb_read_data,  rdat);
    check({tag, "_rd"},         wb_rd,         rd);
    check({tag, "_mem_err"},    mem_err,       exp_err);
  endtask

  // Starts and ends at one time unit after a rising edge with the stage idle.
  // d = cycles the memory waits before acking, counted from the first request cycle.
  task automatic run_op(input logic rw, input logic mr, input logic mw, input logic br,
                        input logic [11:0] pc, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [2:0] rd, input int d, input logic [15:0] rdata);
    logic access;
    int   wait_cycles;
    int   stalls;
    bit   tout;
    access = mr | mw;
    mem_reg_write = rw; mem_mem_read = mr; mem_mem_write = mw; mem_branch = br;
    mem_pc = pc; mem_alu_result = alu; mem_write_data = wd; mem_rd = rd;
    dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
    #1;
    check("branch_target", branch_target, pc);
    check("idle_stall",    stall,         access);
    check("idle_branch",   branch_taken,  br && alu == 16'd0 && !access);
    check("idle_req",      dmem_req,      1'b0);
    if (!access) begin
      @(posedge clk); #1;
      expect_wb("alu_wb", 1'b1, rw, 1'b0, alu, 16'd0, rd);
      return;
    end
    wait_cycles = d;
    tout = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if (d > TO - 1) begin
      wait_cycles = TO - 1;
      tout = 1'b1;
    end
`endif
    stalls = 1;
    @(posedge clk); #1;
    expect_wb("bubble_first", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
    for (int k = 0; k <= wait_cycles; k++) begin
      if (k == wait_cycles && !tout) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      check("acc_req",    dmem_req,     1'b1);
      check("acc_we",     dmem_we,      mw);
      check("acc_addr",   dmem_addr,    alu);
      check("acc_wdata",  dmem_wdata,   wd);
      check("acc_stall",  stall,        k < wait_cycles);
      check("acc_branch", branch_taken, br && alu == 16'd0 && k >= wait_cycles);
      if (stall) stalls++;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (k < wait_cycles) check("acc_bubble", wb_valid, 1'b0);
    end
    check("stall_cycles", stalls, 1 + wait_cycles);
    check("back_idle_req", dmem_req, 1'b0);
    if (tout) begin
      exp_err = 1'b1;
      check("to_valid",     wb_valid,     1'b1);
      check("to_reg_write", wb_reg_write, 1'b0);
      check("to_rd",        wb_rd,        rd);
      check("to_mem_err",   mem_err,      1'b1);
    end else begin
      expect_wb("mem_wb", 1'b1, rw, mr & ~mw, alu, rdata, rd);
    end
  endtask

  task automatic clear_inputs();
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_branch = 1'b0;
    mem_pc = '0; mem_alu_result = '0; mem_write_data = '0; mem_rd = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_wb("reset", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
    check("reset_req",   dmem_req, 1'b0);
    check("reset_stall", stall,    1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ALU op, then load with three wait cycles, then single-cycle store.
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0042, 16'h0000, 3'd3, 0, 16'h0000);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0010, 16'h0000, 3'd2, 3, 16'hBEEF);
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 16'h0020, 16'h1234, 3'd0, 0, 16'h5555);
    // Branch taken and not taken; load+store together behaves as a store.
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 12'h0A4, 16'h0000, 16'h0000, 3'd0, 0, 16'h0000);
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 12'h0A4, 16'h0001, 16'h0000, 3'd0, 0, 16'h0000);
    run_op(1'b1, 1'b1, 1'b1, 1'b0, 12'h010, 16'h0044, 16'hA5A5, 3'd6, 1, 16'h7777);

    // Stray ack while idle must not disturb anything.
    clear_inputs();
    dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("idle_ack_req", dmem_req, 1'b0);
    expect_wb("idle_ack", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);

    // Reset in the middle of an access.
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_alu_result = 16'h0030; mem_rd = 3'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_req", dmem_req, 1'b1);
    reset_n = 1'b0;
    exp_err = 1'b0;
    #1;
    check("rst_req",   dmem_req, 1'b0);
    check("rst_stall", stall,    1'b0);
    expect_wb("rst_mid", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
    clear_inputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack_req", dmem_req, 1'b0);
    expect_wb("late_ack", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);

`ifdef MEM_TIMEOUT_EN
    // Ack on the final allowed cycle completes normally; no ack aborts.
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0050, 16'h0000, 3'd1, TO - 1, 16'hC0DE);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0060, 16'h0000, 3'd4, TO + 5, 16'h0000);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0061, 16'h0000, 3'd4, 0, 16'h0000);
`endif

    for (int i = 0; i < 200; i++) begin
      int   kind;
      logic mr, mw;
      kind = int'($urandom_range(0, 7));
      mr = (kind == 1 || kind == 2 || kind == 7);
      mw = (kind == 3 || kind == 4 || kind == 7);
      run_op(1'($urandom), mr, mw, 1'($urandom),
             12'($urandom),
             ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
             16'($urandom), 3'($urandom),
             int'($urandom_range(0, 5)), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
